// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mul_pkg
//  Purpose : Shared types and constants for the iterative multiplier and the
//            downstream condition/flag logic.
//            - mul_state_t : multiplier control states
//            - NEG/ZER/CAR/OVR : bit positions inside a 4-bit {N,Z,C,V} vector
//            - FLAGW_NZ : write-enable mask that updates only N and Z
//  Revision: 1.0  initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int NEG = 3;
    localparam int ZER = 2;
    localparam int CAR = 1;
    localparam int OVR = 0;

    localparam logic [3:0] FLAGW_NZ = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/mul_flag_unit_datapath.sv
`default_nettype none
// ============================================================================
//  Module  : mul_datapath
//  Purpose : Shift-add datapath of the iterative multiplier.
//            load  : capture multiplicand/multiplier, seed the accumulator
//                    with the addend (MLA) or zero (MUL), clear the counter.
//            step  : one shift-add iteration; the counter advances.
//  Ports   : clk, reset (async, active-high)
//            load, step, src_a, src_b, src_acc, accumulate  (inputs)
//            acc  (running / final sum), last (current step is the final one)
//  Revision: 1.0  initial release
// ============================================================================
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] src_acc,
    input  logic             accumulate,
    output logic [WIDTH-1:0] acc,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_sum;

    // Sum wraps modulo 2^WIDTH; the carry-out is intentionally dropped.
    assign w_sum = r_acc + r_mcand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (load) begin
            r_mcand  <= src_a;
            r_mplier <= src_b;
            r_acc    <= accumulate ? src_acc : '0;
            r_count  <= '0;
        end else if (step) begin
            if (r_mplier[0]) begin
                r_acc <= w_sum;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    assign acc  = r_acc;
    assign last = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mul_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mul_flag_unit
//  Purpose : Iterative MUL/MLA unit producing the result, NZCV flags and
//            per-flag write enables for the condition-flag registers.
//            Fixed latency: WIDTH busy cycles, then a one-cycle done pulse.
//  Ports   : clk, reset (async, active-high)
//            start, flush, SrcA, SrcB, SrcAcc, Accumulate, SetFlags (inputs)
//            busy, done, Result, ALUFlags {N,Z,C,V}, FlagW (outputs)
//  Revision: 1.0  initial release
// ============================================================================
module mul_flag_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcAcc,
    input  logic             Accumulate,
    input  logic             SetFlags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       FlagW
);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic             r_set_flags;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_set_flags <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_set_flags <= SetFlags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control. Flush overrides every transition,
    // including a start presented in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = BUSY;
                    w_load = 1'b1;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start in the done cycle is accepted.
                if (start) begin
                    w_next = BUSY;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
            w_load = 1'b0;
            w_step = 1'b0;
        end
    end

    mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .step       (w_step),
        .src_a      (SrcA),
        .src_b      (SrcB),
        .src_acc    (SrcAcc),
        .accumulate (Accumulate),
        .acc        (w_acc),
        .last       (w_last)
    );

    // ------------------------------------------------------------------
    // Outputs: everything except busy is qualified by done so that the
    // consumer never sees a partial sum or stale flags.
    // ------------------------------------------------------------------
    assign busy   = (r_state == BUSY);
    assign done   = (r_state == DONE);
    assign Result = done ? w_acc : '0;

    always_comb begin
        ALUFlags = 4'b0000;
        FlagW    = 4'b0000;
        if (done) begin
            ALUFlags[NEG] = w_acc[WIDTH-1];
            ALUFlags[ZER] = (w_acc == '0);
            ALUFlags[CAR] = 1'b0;
            ALUFlags[OVR] = 1'b0;
            // C and V are never written so they keep their stored values.
            FlagW = r_set_flags ? FLAGW_NZ : 4'b0000;
        end
    end

endmodule
`default_nettype wire
